mnist_image_checker: RTL and testbench

MNIST_IMAGE_CHECKER -- requirements
Module: mnist_image_checker

---
 rtl/mnist_test_pkg.sv | 25 ++
 rtl/mnist_image_checker_if.sv | 24 ++
 rtl/mnist_label_counter.sv | 28 ++
 rtl/mnist_image_checker.sv | 175 +++++++++++++++++
 tb/tb_mnist_image_checker.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_test_pkg.sv
// Shared types and width helpers for the MNIST image checker.
// Holds the FSM state encoding and the fixed bus widths.
package mnist_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_CHECK,
        S_GAP,
        S_DONE,
        S_HALT
    } state_t;

    localparam int DATA_W    = 8;
    localparam int LABEL_W   = 4;
    localparam int LAT_W     = 4;
    localparam int GAP_W     = 8;
    localparam int CNT_EXTRA = 8;

    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mnist_image_checker_if.sv
// Pattern ROM and classifier-side bus of the MNIST image checker.
// The master side is the checker; the slave side is ROM plus classifier.
interface mnist_image_checker_if #(
    parameter int ADDR_W = 4
);
    import mnist_test_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic [DATA_W-1:0]  dut_data;
    logic               dut_sof;
    logic [LABEL_W-1:0] dut_index;

    modport master (
        output rom_addr, dut_data, dut_sof,
        input  rom_data, dut_index
    );

    modport slave (
        input  rom_addr, dut_data, dut_sof,
        output rom_data, dut_index
    );

endinterface

// File: rtl/mnist_label_counter.sv
// Modulo-NUM_CLASSES label counter stepped alongside the image number.
// Avoids a divider when deriving the expected label.
module mnist_label_counter
    import mnist_test_pkg::*;
#(
    parameter int NUM_CLASSES = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [LABEL_W-1:0] label
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label <= '0;
        end else if (clr) begin
            label <= '0;
        end else if (inc) begin
            if (label == LABEL_W'(NUM_CLASSES - 1))
                label <= '0;
            else
                label <= label + 1'b1;
        end
    end

endmodule

// File: rtl/mnist_image_checker.sv
// Streams ROM images into a classifier and checks each returned label.
// ROM read and output register give two cycles from address to dut_data.
module mnist_image_checker
    import mnist_test_pkg::*;
#(
    parameter int IMAGE_COUNT     = 450,
    parameter int BYTES_PER_IMAGE = 32,
    parameter int RESULT_LATENCY  = 2,
    parameter int NUM_CLASSES     = 10,
    parameter int GAP_CYCLES      = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stop_on_fail,
    input  logic                                loop,
    mnist_image_checker_if.master               bus,
    output logic                                busy,
    output logic                                done,
    output logic                                halted,
    output logic [$clog2(IMAGE_COUNT+1)-1:0]    cur_image,
    output logic [LABEL_W-1:0]                  exp_label,
    output logic [LABEL_W-1:0]                  got_label,
    output logic [$clog2(IMAGE_COUNT+1)+7:0]    pass_count,
    output logic [$clog2(IMAGE_COUNT+1)+7:0]    fail_count,
    output logic [$clog2(IMAGE_COUNT+1)-1:0]    first_fail
);

    localparam int IMG_W  = width_of(IMAGE_COUNT + 1);
    localparam int BC_W   = width_of(BYTES_PER_IMAGE);
    localparam int ADDR_W = width_of(IMAGE_COUNT * BYTES_PER_IMAGE);

    state_t              state, state_nx;
    logic [BC_W-1:0]     bc;
    logic [ADDR_W-1:0]   img_base;
    logic [LAT_W-1:0]    wc;
    logic [GAP_W-1:0]    gc;
    logic                rd_valid, rd_sof;
    logic [DATA_W-1:0]   data_q;
    logic                sof_q;
    logic                loop_q;
    logic                begin_run, adv, wrap, img_end;
    logic                last_byte, last_img, sample, mismatch, lp;

    assign last_byte = (bc == BC_W'(BYTES_PER_IMAGE - 1));
    assign last_img  = (cur_image == IMG_W'(IMAGE_COUNT - 1));
    assign sample    = (state == S_WAIT) && (wc == LAT_W'(RESULT_LATENCY));
    assign mismatch  = (got_label != exp_label);
    assign lp        = (state == S_CHECK) ? loop : loop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        begin_run = 1'b0;
        adv       = 1'b0;
        wrap      = 1'b0;
        img_end   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_HALT: begin
                if (start) begin
                    state_nx  = S_STREAM;
                    begin_run = 1'b1;
                end
            end
            S_STREAM: if (last_byte) state_nx = S_WAIT;
            S_WAIT:   if (sample) state_nx = S_CHECK;
            S_CHECK: begin
                if (mismatch && stop_on_fail)
                    state_nx = S_HALT;
                else if (GAP_CYCLES == 0)
                    img_end = 1'b1;
                else
                    state_nx = S_GAP;
            end
            S_GAP: if (gc == GAP_W'(GAP_CYCLES - 1)) img_end = 1'b1;
            default: state_nx = S_IDLE;
        endcase
        if (img_end) begin
            if (!last_img) begin
                state_nx = S_STREAM;
                adv      = 1'b1;
            end else if (lp) begin
                state_nx = S_STREAM;
                wrap     = 1'b1;
            end else begin
                state_nx = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc         <= '0;
            img_base   <= '0;
            wc         <= '0;
            gc         <= '0;
            rd_valid   <= 1'b0;
            rd_sof     <= 1'b0;
            data_q     <= '0;
            sof_q      <= 1'b0;
            loop_q     <= 1'b0;
            cur_image  <= '0;
            got_label  <= '0;
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            rd_valid <= (state == S_STREAM);
            rd_sof   <= (state == S_STREAM) && (bc == '0);
            sof_q    <= rd_sof;
            if (rd_valid)
                data_q <= bus.rom_data;
            // bc wraps to 0 on the last byte since BYTES_PER_IMAGE is 2^n
            if (state == S_STREAM)
                bc <= bc + 1'b1;
            else if (begin_run)
                bc <= '0;
            wc <= (state == S_WAIT) ? wc + 1'b1 : '0;
            gc <= (state == S_GAP) ? gc + 1'b1 : '0;
            if (sample)
                got_label <= bus.dut_index;
            if (state == S_CHECK)
                loop_q <= loop;
            if (begin_run || wrap) begin
                cur_image <= '0;
                img_base  <= '0;
            end else if (adv) begin
                cur_image <= cur_image + 1'b1;
                img_base  <= img_base + ADDR_W'(BYTES_PER_IMAGE);
            end
            if (begin_run) begin
                pass_count <= '0;
                fail_count <= '0;
                first_fail <= '0;
            end else if (state == S_CHECK) begin
                if (!mismatch) begin
                    if (pass_count != '1)
                        pass_count <= pass_count + 1'b1;
                end else begin
                    if (fail_count == '0)
                        first_fail <= cur_image;
                    if (fail_count != '1)
                        fail_count <= fail_count + 1'b1;
                end
            end
        end
    end

    mnist_label_counter #(
        .NUM_CLASSES (NUM_CLASSES)
    ) u_label (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (begin_run | wrap),
        .inc   (adv),
        .label (exp_label)
    );

    assign bus.rom_addr = (state == S_STREAM) ?
                          img_base + ADDR_W'(bc) : '0;
    assign bus.dut_data = data_q;
    assign bus.dut_sof  = sof_q;

    assign busy   = (state == S_STREAM) || (state == S_WAIT) ||
                    (state == S_CHECK)  || (state == S_GAP);
    assign done   = (state == S_DONE);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_mnist_image_checker.sv
// Bench for mnist_image_checker: byte-address ROM, modelled classifier
// with an injectable wrong answer, directed and randomized runs.
module tb_mnist_image_checker;

    localparam int IC  = 3;
    localparam int BPI = 4;
    localparam int LAT = 2;
    localparam int NC  = 10;
    localparam int GAP = 0;
    localparam int AW  = $clog2(IC * BPI);
    localparam int IW  = $clog2(IC + 1);
    localparam int CW  = IW + 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop_on_fail = 1'b0;
    logic          loop = 1'b0;
    logic          busy, done, halted;
    logic [IW-1:0] cur_image, first_fail;
    logic [3:0]    exp_label, got_label;
    logic [CW-1:0] pass_count, fail_count;

    int n_cmp = 0;
    int n_err = 0;
    int fault_img = 3;
    int fault_val = 0;
    int cap = 0;
    int img_no = 0;
    int byte_q[$];
    int lbl_q[$];
    int addr_q[$];

    mnist_image_checker_if #(.ADDR_W(AW)) bus ();

    mnist_image_checker #(
        .IMAGE_COUNT     (IC),
        .BYTES_PER_IMAGE (BPI),
        .RESULT_LATENCY  (LAT),
        .NUM_CLASSES     (NC),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .loop         (loop),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .halted       (halted),
        .cur_image    (cur_image),
        .exp_label    (exp_label),
        .got_label    (got_label),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .first_fail   (first_fail)
    );

    always #5 clk = ~clk;

    // ROM contents equal the byte address, one cycle read latency
    always @(posedge clk) bus.rom_data <= 8'(bus.rom_addr);

    // Classifier model and stream monitor
    always @(negedge clk) begin
        if (bus.dut_sof) begin
            cap = BPI;
            img_no = int'(bus.dut_data) / BPI;
            lbl_q.push_back(int'(exp_label));
            if (img_no == fault_img)
                bus.dut_index = 4'(fault_val);
            else
                bus.dut_index = 4'(img_no % NC);
        end
        if (cap > 0) begin
            byte_q.push_back(int'(bus.dut_data));
            cap = cap - 1;
        end
        if (busy)
            addr_q.push_back(int'(bus.rom_addr));
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_case(input int stop, input int fimg, input int fval,
                            input int passes, input bit poke);
        int cyc, p, f, first, n, halt, bad, lbad, mx;
        int img, ev, ans, last_img, last_ans, last_exp;
        fault_img = fimg;
        fault_val = fval;
        stop_on_fail = stop[0];
        loop = (passes > 1);
        byte_q.delete();
        lbl_q.delete();
        addr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (passes > 1) begin
            cyc = 0;
            while (lbl_q.size() < IC * (passes - 1) + 1 && !halted &&
                   cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            loop = 1'b0;
        end
        if (poke) begin
            cyc = 0;
            while (lbl_q.size() < 1 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            repeat (3) @(negedge clk);
            check("busy_in_wait", busy, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!(done || halted) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("finish_in_time", cyc < 1000, 1);

        p = 0; f = 0; first = 0; n = 0; halt = 0;
        last_img = 0; last_ans = 0; last_exp = 0;
        for (int k = 0; k < passes * IC; k++) begin
            img = k % IC;
            ev  = img % NC;
            ans = (img == fimg) ? fval : ev;
            n++;
            last_img = img;
            last_ans = ans;
            last_exp = ev;
            if (ans == ev) begin
                p++;
            end else begin
                if (f == 0) first = img;
                f++;
                if (stop != 0) begin
                    halt = 1;
                    break;
                end
            end
        end

        bad = 0;
        for (int i = 0; i < byte_q.size(); i++)
            if (byte_q[i] != ((i / BPI) % IC) * BPI + i % BPI) bad++;
        lbad = 0;
        for (int i = 0; i < lbl_q.size(); i++)
            if (lbl_q[i] != (i % IC) % NC) lbad++;
        mx = 0;
        foreach (addr_q[i]) if (addr_q[i] > mx) mx = addr_q[i];

        check("done", done, halt == 0);
        check("halted", halted, halt);
        check("busy_end", busy, 0);
        check("pass_count", pass_count, p);
        check("fail_count", fail_count, f);
        check("first_fail", first_fail, first);
        check("got_label", got_label, last_ans);
        check("exp_label", exp_label, last_exp);
        check("cur_image", cur_image, last_img);
        check("sof_pulses", lbl_q.size(), n);
        check("byte_total", byte_q.size(), n * BPI);
        check("byte_order_errs", bad, 0);
        check("label_seq_errs", lbad, 0);
        check("max_rom_addr", mx, last_img * BPI + BPI - 1);
        check("dut_data_hold", bus.dut_data, last_img * BPI + BPI - 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_halted", halted, 0);
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        check("rst_cur_image", cur_image, 0);
        check("rst_exp_label", exp_label, 0);
        check("rst_got_label", got_label, 0);
        check("rst_dut_data", bus.dut_data, 0);
        check("rst_dut_sof", bus.dut_sof, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_case(0, 3, 0, 1, 1'b0);
        run_case(1, 1, 7, 1, 1'b0);
        run_case(0, 1, 7, 1, 1'b0);
        run_case(0, 3, 0, 3, 1'b0);
        run_case(0, 3, 0, 1, 1'b1);

        // Asynchronous reset while image 1 is streaming
        fault_img = 3;
        stop_on_fail = 1'b0;
        loop = 1'b0;
        lbl_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (lbl_q.size() < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_image1", lbl_q.size(), 2);
        check("pre_rst_pass", pass_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pass", pass_count, 0);
        check("mid_rst_cur_image", cur_image, 0);
        check("mid_rst_dut_data", bus.dut_data, 0);
        check("mid_rst_rom_addr", bus.rom_addr, 0);
        check("mid_rst_exp_label", exp_label, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_case(0, 3, 0, 1, 1'b0);

        for (int r = 0; r < 6; r++)
            run_case(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(1, 2)),
                     1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
